// File: rtl/rv32m_div_unit.sv
// ---------------------------------------------------------------------------
// rv32m_div_unit
//
// Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU ops.
// One operation is in flight at a time. Signed operands are converted to
// magnitudes when the op is accepted. One quotient bit is produced per cycle
// in CALC. FIX restores the signs and selects quotient or remainder. DONE
// holds the result until writeback acknowledges it. Divide-by-zero and
// signed overflow skip the iteration and go straight to DONE.
//
// Ports:
//   CLK, RST   clock (rising edge), synchronous active-high reset
//   start      issue valid, only taken while ready=1
//   ready      unit idle and able to accept an op
//   is_signed  1 = DIV/REM, 0 = DIVU/REMU
//   div_type   1 = return quotient, 0 = return remainder
//   dividend   rs1 value
//   divisor    rs2 value
//   rd_in      destination register of the issued op
//   flush      abandon any op and return to idle
//   busy       iterating (CALC) or correcting signs (FIX)
//   done       result valid, held until done_ack
//   done_ack   writeback has consumed the result
//   result     quotient or remainder, as chosen by div_type
//   rd_out     destination register tagged with result
// ---------------------------------------------------------------------------
module rv32m_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  output logic             ready,
  input  logic             is_signed,
  input  logic             div_type,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [4:0]       rd_in,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  input  logic             done_ack,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       rd_out
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] quo;        // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] rem;        // partial remainder, always below the divisor magnitude
  logic [WIDTH-1:0] dvs_mag_q;
  logic [CNT_W-1:0] cnt;
  logic             neg_q;
  logic             neg_r;
  logic             type_q;

  // Acceptance-time decode.
  logic             accept;
  logic             div_zero;
  logic             overflow;
  logic             special;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] special_result;

  assign accept   = (state == IDLE) && start && !flush;
  assign div_zero = (divisor == '0);
  assign overflow = is_signed && (dividend == MIN_NEG) && (&divisor);
  assign special  = div_zero || overflow;
  assign dvd_neg  = is_signed && dividend[WIDTH-1];
  assign dvs_neg  = is_signed && divisor[WIDTH-1];
  assign dvd_mag  = dvd_neg ? -dividend : dividend;
  assign dvs_mag  = dvs_neg ? -divisor : divisor;

  always_comb begin
    if (div_zero) special_result = div_type ? '1 : dividend;
    else          special_result = div_type ? MIN_NEG : '0;
  end

  // One restoring step. The shifted remainder needs one extra bit so that
  // the sign of the trial subtraction is exact.
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] diff;

  assign rem_shift = {rem, quo[WIDTH-1]};
  assign diff      = rem_shift - {1'b0, dvs_mag_q};

  // Sign correction in FIX: the quotient is negative when the operand signs
  // differ, and the remainder follows the sign of the dividend.
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign q_fix = neg_q ? -quo : quo;
  assign r_fix = neg_r ? -rem : rem;

  // State register.
  // NOTE: clocked blocks use non-blocking (<=) so every register samples
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and state-decoded outputs.
  // NOTE: every output of this block gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (accept) state_next = special ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == CNT_LAST) state_next = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (done_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // flush overrides everything, including a start in the same cycle.
    if (flush) state_next = IDLE;
  end

  // Datapath.
  always_ff @(posedge CLK) begin
    if (RST) begin
      quo       <= '0;
      rem       <= '0;
      dvs_mag_q <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      type_q    <= 1'b0;
      result    <= '0;
      rd_out    <= '0;
    end else if (accept) begin
      quo       <= dvd_mag;
      rem       <= '0;
      dvs_mag_q <= dvs_mag;
      cnt       <= '0;
      neg_q     <= dvd_neg ^ dvs_neg;
      neg_r     <= dvd_neg;
      type_q    <= div_type;
      rd_out    <= rd_in;
      if (special) result <= special_result;
    end else if (state == CALC) begin
      cnt <= cnt + CNT_W'(1);
      if (!diff[WIDTH]) begin
        rem <= diff[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b1};
      end else begin
        rem <= rem_shift[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b0};
      end
    end else if (state == FIX) begin
      result <= type_q ? q_fix : r_fix;
    end
  end

endmodule

// File: tb/tb_rv32m_div_unit.sv
// ---------------------------------------------------------------------------
// tb_rv32m_div_unit
//
// Self-checking bench for rv32m_div_unit. Expected results come from a
// behavioural model built on plain integer division. A negedge monitor
// compares result/rd_out against the model on every cycle done is high.
// Directed ops also check literal values, latency, busy span and the
// handshake. These are followed by randomized ops.
// ---------------------------------------------------------------------------
module tb_rv32m_div_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic        ready;
  logic        is_signed;
  logic        div_type;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [4:0]  rd_in;
  logic        flush;
  logic        busy;
  logic        done;
  logic        done_ack;
  logic [31:0] result;
  logic [4:0]  rd_out;

  rv32m_div_unit #(.WIDTH(32)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .ready     (ready),
    .is_signed (is_signed),
    .div_type  (div_type),
    .dividend  (dividend),
    .divisor   (divisor),
    .rd_in     (rd_in),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .done_ack  (done_ack),
    .result    (result),
    .rd_out    (rd_out)
  );

  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;

  logic        exp_valid = 1'b0;
  logic [31:0] exp_result = '0;
  logic [4:0]  exp_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // RISC-V M division semantics written directly from the ISA rules.
  function automatic logic [31:0] model(input logic s, input logic t,
                                        input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    if (b == 32'd0) return t ? 32'hFFFF_FFFF : a;
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return t ? 32'h8000_0000 : 32'd0;
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      return t ? 32'(sa / sb) : 32'(sa % sb);
    end
    return t ? a / b : a % b;
  endfunction

  function automatic bit is_special(input logic s, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Compare process: whenever done is high the held result must match the
  // model; done with no op outstanding is itself an error.
  always @(negedge CLK) begin
    if (!RST && done) begin
      if (exp_valid) begin
        check("mon_result", result, exp_result);
        check("mon_rd", 32'(rd_out), 32'(exp_rd));
      end else begin
        check("mon_unexpected_done", 32'(done), 32'd0);
      end
    end
  end

  // Present an op and wait for its acceptance edge; returns in cycle 1.
  task automatic issue(input logic s, input logic t, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    exp_result = model(s, t, a, b);
    exp_rd     = rd;
    is_signed  = s;
    div_type   = t;
    dividend   = a;
    divisor    = b;
    rd_in      = rd;
    start      = 1'b1;
    @(posedge CLK);
    #1;
    start      = 1'b0;
    exp_valid  = 1'b1;
  endtask

  // Full op: issue, measure latency and busy span, hold done for 'hold'
  // cycles (with an ignored start pulse), then ack together with a start
  // that must not be accepted.
  task automatic do_op(input logic s, input logic t, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input int hold,
                       input bit use_lit, input logic [31:0] lit);
    int lat;
    int busy_cnt;
    bit sp;
    logic [31:0] held;
    sp = is_special(s, a, b);
    issue(s, t, a, b, rd);
    lat = 1;
    busy_cnt = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      // done_ack outside DONE must be ignored.
      done_ack = (lat == 5);
      @(posedge CLK);
      #1;
      lat++;
    end
    done_ack = 1'b0;
    check("latency", 32'(lat), sp ? 32'd1 : 32'd34);
    check("busy_cycles", 32'(busy_cnt), sp ? 32'd0 : 32'd33);
    check("ready_in_done", 32'(ready), 32'd0);
    check("rd_out", 32'(rd_out), 32'(rd));
    if (use_lit) check("literal_result", result, lit);
    held = result;
    for (int i = 0; i < hold; i++) begin
      start    = (i == 1);
      dividend = 32'd77;
      divisor  = 32'd5;
      @(posedge CLK);
      #1;
      start = 1'b0;
      check("done_held", 32'(done), 32'd1);
      check("result_stable", result, held);
    end
    done_ack = 1'b1;
    start    = (hold > 0);
    @(posedge CLK);
    #1;
    done_ack  = 1'b0;
    start     = 1'b0;
    exp_valid = 1'b0;
    check("ready_after_ack", 32'(ready), 32'd1);
    check("done_after_ack", 32'(done), 32'd0);
    @(posedge CLK);
    #1;
    check("idle_after_ack", 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    int done_seen;
    logic s, t;
    logic [31:0] a, b;
    RST = 1'b1; start = 1'b0; is_signed = 1'b0; div_type = 1'b0;
    dividend = '0; divisor = '0; rd_in = '0; flush = 1'b0; done_ack = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd", 32'(rd_out), 32'd0);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // Directed ops with hand-computed expectations.
    do_op(1'b0, 1'b1, 32'd100, 32'd7, 5'd5, 0, 1'b1, 32'd14);
    do_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 5'd6, 0, 1'b1, 32'hFFFF_FFFF);
    do_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd7, 0, 1'b1, 32'hFFFF_FFFD);
    do_op(1'b0, 1'b1, 32'h1234, 32'd0, 5'd8, 0, 1'b1, 32'hFFFF_FFFF);
    do_op(1'b0, 1'b0, 32'h1234, 32'd0, 5'd9, 0, 1'b1, 32'h1234);
    do_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0, 1'b1, 32'h8000_0000);
    do_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0, 1'b1, 32'd0);
    do_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, 5'd12, 0, 1'b1, 32'd1);

    // flush in CALC cycle 10: op abandoned, done never rises.
    issue(1'b0, 1'b1, 32'd1000, 32'd3, 5'd13);
    lat = 1;
    while (lat < 10) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    flush = 1'b1;
    @(posedge CLK);
    #1;
    flush     = 1'b0;
    exp_valid = 1'b0;
    check("flush_ready", 32'(ready), 32'd1);
    check("flush_busy", 32'(busy), 32'd0);
    done_seen = 0;
    repeat (40) begin
      @(posedge CLK);
      #1;
      if (done) done_seen++;
    end
    check("flush_no_done", 32'(done_seen), 32'd0);
    do_op(1'b0, 1'b1, 32'd9, 32'd3, 5'd14, 0, 1'b1, 32'd3);

    // flush together with start: op dropped.
    start = 1'b1; flush = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(posedge CLK);
    #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start_ready", 32'(ready), 32'd1);

    // Long hold with an ignored start pulse during DONE.
    do_op(1'b0, 1'b0, 32'd1001, 32'd10, 5'd15, 5, 1'b1, 32'd1);

    // flush in DONE discards the held result.
    issue(1'b0, 1'b1, 32'd5, 32'd0, 5'd16);
    flush = 1'b1;
    @(posedge CLK);
    #1;
    flush     = 1'b0;
    exp_valid = 1'b0;
    check("flush_done_cleared", 32'(done), 32'd0);
    check("flush_done_ready", 32'(ready), 32'd1);

    // Reset at CALC cycle 20.
    issue(1'b0, 1'b1, 32'd123456, 32'd17, 5'd21);
    lat = 1;
    while (lat < 20) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    RST = 1'b1;
    @(posedge CLK);
    #1;
    exp_valid = 1'b0;
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_rd", 32'(rd_out), 32'd0);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // Randomized ops, biased toward signs, zero divisors and overflow.
    for (int n = 0; n < 40; n++) begin
      s = 1'($urandom);
      t = 1'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: b = -$urandom_range(1, 15);
        4: a = $urandom_range(0, 100);
        default: ;
      endcase
      do_op(s, t, a, b, 5'($urandom), $urandom_range(0, 3), 1'b0, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
